// File: rtl/instr_encoder.sv
// instr_encoder: packs OP-IMM/LOAD/STORE fields into RV32I words with sequential addresses
// through a single registered valid/ready stage; illegal requests are dropped and flagged.
module instr_encoder #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              restart,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        fmt,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        funct3,
    input  logic [31:0]       imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic [CNT_W-1:0]  word_count,
    output logic [CNT_W-1:0]  drop_count,
    output logic              err_range,
    output logic              err_fmt
);
    logic              r_valid;
    logic [31:0]       r_instr;
    logic [ADDR_W-1:0] r_out_addr;
    logic [ADDR_W-1:0] r_addr;
    logic [CNT_W-1:0]  r_word_count;
    logic [CNT_W-1:0]  r_drop_count;
    logic              r_err_range;
    logic              r_err_fmt;
    logic              w_accept;
    logic              w_fmt_bad;
    logic              w_range_bad;
    logic              w_legal;
    logic [6:0]        w_opcode;
    logic [31:0]       w_word;
    logic [ADDR_W-1:0] w_addr_now;
    // Value fits in 12 signed bits when imm[31:11] is a pure sign extension.
    assign w_range_bad = !((imm[31:11] == '0) || (imm[31:11] == '1));
    assign w_fmt_bad   = fmt == 2'd3;
    assign w_legal     = !w_range_bad && !w_fmt_bad;
    assign in_ready    = !r_valid || out_ready;
    assign w_accept    = in_valid && in_ready;
    assign w_opcode    = fmt == 2'd0 ? 7'b0010011 : 7'b0000011;
    assign w_word      = fmt == 2'd2 ? {imm[11:5], rs2, rs1, funct3, imm[4:0], 7'b0100011}
                                     : {imm[11:0], rs1, funct3, rd, w_opcode};
    assign w_addr_now  = restart ? BASE_ADDR : r_addr;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid      <= 1'b0;
            r_instr      <= '0;
            r_out_addr   <= '0;
            r_addr       <= BASE_ADDR;
            r_word_count <= '0;
            r_drop_count <= '0;
            r_err_range  <= 1'b0;
            r_err_fmt    <= 1'b0;
        end else if (w_accept && w_legal) begin
            r_valid      <= 1'b1;
            r_instr      <= w_word;
            r_out_addr   <= w_addr_now;
            r_addr       <= w_addr_now + ADDR_W'(4);
            r_word_count <= &r_word_count ? r_word_count : r_word_count + 1'b1;
        end else begin
            if (out_ready) r_valid <= 1'b0;
            if (restart) r_addr <= BASE_ADDR;
            if (w_accept) begin
                r_drop_count <= &r_drop_count ? r_drop_count : r_drop_count + 1'b1;
                r_err_range  <= r_err_range | w_range_bad;
                r_err_fmt    <= r_err_fmt | w_fmt_bad;
            end
        end
    end
    assign out_valid  = r_valid;
    assign out_instr  = r_instr;
    assign out_addr   = r_out_addr;
    assign word_count = r_word_count;
    assign drop_count = r_drop_count;
    assign err_range  = r_err_range;
    assign err_fmt    = r_err_fmt;
endmodule
